// File: rtl/bbuf_acc_pkg.sv
// Shared types and helpers for the bias-gradient accumulation buffer.
// The saturating add is shared by the accumulate pipeline and any future readers of the entry format.
package bbuf_acc_pkg;

    localparam int RES_W         = 16;
    localparam int BUF_DEPTH_DEF = 256;

    typedef logic signed [RES_W-1:0] bias_t;

    typedef enum logic {
        ST_IDLE,
        ST_CLEAR
    } bbuf_state_t;

    function automatic int bw(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int ADDR_W_DEF = bw(BUF_DEPTH_DEF);

    // Add one bit of headroom, then clamp to the signed range if the top two bits disagree
    function automatic bias_t sat_add(input bias_t a, input bias_t b);
        logic signed [RES_W:0] s;
        s = {a[RES_W-1], a} + {b[RES_W-1], b};
        if (s[RES_W] != s[RES_W-1])
            return s[RES_W] ? {1'b1, {(RES_W-1){1'b0}}} : {1'b0, {(RES_W-1){1'b1}}};
        return s[RES_W-1:0];
    endfunction

endpackage

// File: rtl/bbuf_acc_if.sv
// Accumulate and readout port bundle between ddr2pbuf/writeback and bbuf_acc.
interface bbuf_acc_if import bbuf_acc_pkg::*; #(
    parameter int ADDR_W = ADDR_W_DEF
);

    logic              acc_en;
    logic              acc_new;
    logic [ADDR_W-1:0] acc_addr;
    bias_t             acc_data;
    logic              rd_en;
    logic              rd_ready;
    logic [ADDR_W-1:0] rd_addr;
    bias_t             rd_data;
    logic              rd_valid;

    modport master (
        output acc_en, acc_new, acc_addr, acc_data, rd_en, rd_addr,
        input  rd_ready, rd_data, rd_valid
    );

    modport slave (
        input  acc_en, acc_new, acc_addr, acc_data, rd_en, rd_addr,
        output rd_ready, rd_data, rd_valid
    );

endinterface

// File: rtl/bbuf_acc_ram.sv
// Simple dual-port entry RAM, read-first, one-cycle read latency, contents not reset.
module bbuf_ram import bbuf_acc_pkg::*; #(
    parameter int DEPTH  = 256,
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  bias_t             wdata,
    input  logic [ADDR_W-1:0] raddr,
    output bias_t             rdata
);

    bias_t mem [DEPTH];

    // A same-address read and write on one edge returns the old word
    always_ff @(posedge clk) begin
        if (we)
            mem[waddr] <= wdata;
        rdata <= mem[raddr];
    end

endmodule

// File: rtl/bbuf_acc.sv
// Bias-gradient accumulation buffer: read-modify-write pipeline with S2/S3 forwarding,
// bulk clear sequencer and a forwarded readout port.
module bbuf_acc import bbuf_acc_pkg::*; #(
    parameter int BUF_DEPTH = BUF_DEPTH_DEF,
    parameter int ADDR_W    = bw(BUF_DEPTH)
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       clear_start,
    output logic       clear_done,
    output logic       acc_drop,
    bbuf_acc_if.slave  bus
);

    bbuf_state_t       state, state_nxt;
    logic [ADDR_W-1:0] clr_addr;

    logic              s1_valid, s1_new;
    logic [ADDR_W-1:0] s1_addr;
    bias_t             s1_data, s1_old, s1_sum;
    logic              s2_valid, s3_valid;
    logic [ADDR_W-1:0] s2_addr, s3_addr;
    bias_t             s2_sum, s3_sum;

    logic              rdp_valid;
    logic [ADDR_W-1:0] rdp_addr;
    bias_t             rd_fwd, rd_hold;

    logic              acc_take, rd_take, clr_write, clr_last;
    logic              ram_we;
    logic [ADDR_W-1:0] ram_waddr, ram_raddr;
    bias_t             ram_wdata, ram_rdata;

    assign acc_take     = (state == ST_IDLE) && bus.acc_en;
    assign bus.rd_ready = (state == ST_IDLE) && !bus.acc_en;
    assign rd_take      = bus.rd_ready && bus.rd_en;
    // Clear writes hold off until the accumulate pipeline has drained its writes
    assign clr_write    = (state == ST_CLEAR) && !s1_valid && !s2_valid;
    assign clr_last     = clr_write && (clr_addr == ADDR_W'(BUF_DEPTH - 1));

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (clear_start) state_nxt = ST_CLEAR;
            ST_CLEAR: if (!clear_start && clr_last) state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    // S2 is the newest pending write, S3 covers the read-first collision one edge later
    always_comb begin
        s1_old = ram_rdata;
        if (s2_valid && s2_addr == s1_addr)
            s1_old = s2_sum;
        else if (s3_valid && s3_addr == s1_addr)
            s1_old = s3_sum;
        s1_sum = sat_add(s1_new ? bias_t'('0) : s1_old, s1_data);

        rd_fwd = ram_rdata;
        if (s2_valid && s2_addr == rdp_addr)
            rd_fwd = s2_sum;
        else if (s3_valid && s3_addr == rdp_addr)
            rd_fwd = s3_sum;
    end

    always_comb begin
        ram_we    = rst && (s2_valid || clr_write);
        ram_waddr = s2_valid ? s2_addr : clr_addr;
        ram_wdata = s2_valid ? s2_sum : bias_t'('0);
        ram_raddr = bus.acc_en ? bus.acc_addr : bus.rd_addr;
    end

    assign bus.rd_valid = rdp_valid;
    assign bus.rd_data  = rdp_valid ? rd_fwd : rd_hold;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= ST_IDLE;
            clr_addr   <= '0;
            clear_done <= 1'b1;
            acc_drop   <= 1'b0;
            s1_valid   <= 1'b0;
            s2_valid   <= 1'b0;
            s3_valid   <= 1'b0;
            rdp_valid  <= 1'b0;
            rd_hold    <= '0;
        end else begin
            state     <= state_nxt;
            s1_valid  <= acc_take;
            s2_valid  <= s1_valid;
            s3_valid  <= s2_valid;
            rdp_valid <= rd_take;
            if (rdp_valid)
                rd_hold <= rd_fwd;
            if (clear_start) begin
                clr_addr   <= '0;
                acc_drop   <= 1'b0;
                clear_done <= 1'b0;
            end else begin
                if (clr_write)
                    clr_addr <= clr_addr + ADDR_W'(1);
                if (state == ST_CLEAR && bus.acc_en)
                    acc_drop <= 1'b1;
                if (state == ST_IDLE)
                    clear_done <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (acc_take) begin
            s1_new  <= bus.acc_new;
            s1_addr <= bus.acc_addr;
            s1_data <= bus.acc_data;
        end
        s2_addr <= s1_addr;
        s2_sum  <= s1_sum;
        s3_addr <= s2_addr;
        s3_sum  <= s2_sum;
        if (rd_take)
            rdp_addr <= bus.rd_addr;
    end

    bbuf_ram #(
        .DEPTH  (BUF_DEPTH),
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .waddr (ram_waddr),
        .wdata (ram_wdata),
        .raddr (ram_raddr),
        .rdata (ram_rdata)
    );

endmodule
